// File: rtl/pmod_spi_master.sv
// SPI master for PMOD headers: framed chip-selects, start/done handshake,
// configurable width, divider, mode and bit order, with MISO capture.
module pmod_spi_master #(
  parameter int DATA_W    = 32,
  parameter int CLK_DIV   = 250,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int MSB_FIRST = 1,
  parameter int NUM_CS    = 1,
  parameter int CSW       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CSW-1:0]    cs_sel,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic [NUM_CS-1:0] csn,
  output logic              sck,
  output logic              mosi,
  input  logic              miso
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(2 * DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_MAX = CNT_W'(2 * DATA_W);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(2 * DATA_W - 1);
  localparam logic [CSW:0] NCS = (CSW + 1)'(NUM_CS);
  localparam logic [NUM_CS-1:0] ONE = NUM_CS'(1);
  localparam logic IDLE_SCK = (CPOL != 0);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div;
  logic [CNT_W-1:0]  hcnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              wrap;
  logic              cs_ok;
  logic              lead;
  logic              do_sample;
  logic              do_drive;

  function automatic logic first_bit(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
  endfunction

  function automatic logic [DATA_W-1:0] shl(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? {v[DATA_W-2:0], 1'b0}
                            : {1'b0, v[DATA_W-1:1]};
  endfunction

  function automatic logic [DATA_W-1:0] rx_in(
    input logic [DATA_W-1:0] v,
    input logic              b
  );
    return (MSB_FIRST != 0) ? {v[DATA_W-2:0], b}
                            : {b, v[DATA_W-1:1]};
  endfunction

  assign wrap  = (div == DIV_MAX);
  assign cs_ok = ({1'b0, cs_sel} < NCS);
  // hcnt holds toggles already made, so an even count means the next is leading
  assign lead      = ~hcnt[0];
  assign do_sample = (CPHA == 0) ? lead : ~lead;
  assign do_drive  = (CPHA == 0) ? (~lead && (hcnt != HALF_LAST))
                                 : lead;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div     <= '0;
      hcnt    <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      csn     <= '1;
      sck     <= IDLE_SCK;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      div  <= (state == IDLE || wrap) ? '0 : div + 1'b1;
      unique case (state)
        IDLE: begin
          hcnt <= '0;
          if (start && cs_ok) begin
            state <= SETUP;
            busy  <= 1'b1;
            csn   <= ~(ONE << cs_sel);
            rx_sh <= '0;
            if (CPHA == 0) begin
              mosi  <= first_bit(tx_data);
              tx_sh <= shl(tx_data);
            end else begin
              tx_sh <= tx_data;
            end
          end
        end
        SETUP, SHIFT: begin
          if (wrap) begin
            if (state == SHIFT && hcnt == HALF_MAX) begin
              state <= HOLD;
            end else begin
              state <= SHIFT;
              sck   <= ~sck;
              hcnt  <= hcnt + 1'b1;
              if (do_sample) rx_sh <= rx_in(rx_sh, miso);
              if (do_drive) begin
                mosi  <= first_bit(tx_sh);
                tx_sh <= shl(tx_sh);
              end
            end
          end
        end
        HOLD: begin
          if (wrap) begin
            state <= GAP;
            csn   <= '1;
          end
        end
        GAP: begin
          if (wrap) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            rx_data <= rx_sh;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmod_spi_master.sv
// Scoreboard bench for pmod_spi_master: three configurations
// covering timing, modes, bit order, chip select, handshake, reset.
module tb_pmod_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // A: mode 0, MSB first, 4 slaves, loopback
  logic       a_start = 1'b0;
  logic [7:0] a_tx = '0;
  logic [1:0] a_cs = '0;
  logic       a_busy, a_done, a_sck, a_mosi, a_miso;
  logic [7:0] a_rx;
  logic [3:0] a_csn;
  assign a_miso = a_mosi;

  pmod_spi_master #(.DATA_W(8), .CLK_DIV(2), .CPOL(0), .CPHA(0),
                    .MSB_FIRST(1), .NUM_CS(4)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .tx_data(a_tx),
    .cs_sel(a_cs), .busy(a_busy), .done(a_done), .rx_data(a_rx),
    .csn(a_csn), .sck(a_sck), .mosi(a_mosi), .miso(a_miso));

  // B: mode 3, MSB first, model slave returns 0x3C
  logic       b_start = 1'b0;
  logic [7:0] b_tx = '0;
  logic [0:0] b_cs = '0;
  logic       b_busy, b_done, b_sck, b_mosi;
  logic       b_miso = 1'b0;
  logic [7:0] b_rx;
  logic [0:0] b_csn;
  logic [7:0] b_sh = '0;

  pmod_spi_master #(.DATA_W(8), .CLK_DIV(2), .CPOL(1), .CPHA(1),
                    .MSB_FIRST(1), .NUM_CS(1)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .tx_data(b_tx),
    .cs_sel(b_cs), .busy(b_busy), .done(b_done), .rx_data(b_rx),
    .csn(b_csn), .sck(b_sck), .mosi(b_mosi), .miso(b_miso));

  always @(negedge b_csn[0]) b_sh = 8'h3C;
  always @(negedge b_sck)
    if (b_csn[0] === 1'b0) begin
      b_miso = b_sh[7];
      b_sh = {b_sh[6:0], 1'b0};
    end

  // C: mode 0, LSB first, 3 slaves, loopback
  logic       c_start = 1'b0;
  logic [7:0] c_tx = '0;
  logic [1:0] c_cs = '0;
  logic       c_busy, c_done, c_sck, c_mosi, c_miso;
  logic [7:0] c_rx;
  logic [2:0] c_csn;
  assign c_miso = c_mosi;

  pmod_spi_master #(.DATA_W(8), .CLK_DIV(2), .CPOL(0), .CPHA(0),
                    .MSB_FIRST(0), .NUM_CS(3)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .tx_data(c_tx),
    .cs_sel(c_cs), .busy(c_busy), .done(c_done), .rx_data(c_rx),
    .csn(c_csn), .sck(c_sck), .mosi(c_mosi), .miso(c_miso));

  typedef struct {
    logic [7:0] tx;
    logic [1:0] cs;
  } exp_t;
  exp_t       a_q[$];
  logic [7:0] b_q[$];
  logic [7:0] c_q[$];

  int a_busy_n, a_csn_n, a_gap_n, a_rise_n;
  logic [3:0] a_csn_seen;
  logic [7:0] a_bits;
  logic a_sck_p;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      a_busy_n = 0; a_csn_n = 0; a_gap_n = 0; a_rise_n = 0;
      a_csn_seen = 4'hf; a_bits = '0;
    end else begin
      if (a_busy) a_busy_n++;
      if (a_busy && a_csn == 4'hf) a_gap_n++;
      if (a_csn != 4'hf) begin
        a_csn_n++;
        a_csn_seen = a_csn;
      end
      if (a_sck === 1'b1 && a_sck_p === 1'b0) begin
        a_rise_n++;
        a_bits = {a_bits[6:0], a_mosi};
      end
      if (a_done) begin
        if (a_q.size() == 0) begin
          chk("a_spurious_done", 1, 0);
        end else begin
          e = a_q.pop_front();
          chk("a_rx", a_rx, e.tx);
          chk("a_mosi_bits", a_bits, e.tx);
          chk("a_rises", a_rise_n, 8);
          chk("a_busy_len", a_busy_n, 38);
          chk("a_csn_len", a_csn_n, 36);
          chk("a_gap_len", a_gap_n, 2);
          chk("a_csn_sel", a_csn_seen, 4'hf ^ (4'b0001 << e.cs));
        end
        a_busy_n = 0; a_csn_n = 0; a_gap_n = 0; a_rise_n = 0;
        a_csn_seen = 4'hf;
      end
    end
    a_sck_p = a_sck;
  end

  int b_rise_n, c_rise_n;
  logic [7:0] b_bits, c_bits;
  logic b_sck_p, c_sck_p, c_first;

  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      b_rise_n = 0; c_rise_n = 0; b_bits = '0; c_bits = '0;
      c_first = 1'b0;
    end else begin
      if (b_sck === 1'b1 && b_sck_p === 1'b0) begin
        b_rise_n++;
        b_bits = {b_bits[6:0], b_mosi};
      end
      if (c_sck === 1'b1 && c_sck_p === 1'b0) begin
        if (c_rise_n == 0) c_first = c_mosi;
        c_rise_n++;
        c_bits = {c_mosi, c_bits[7:1]};
      end
      if (b_done) begin
        if (b_q.size() == 0) begin
          chk("b_spurious_done", 1, 0);
        end else begin
          e = b_q.pop_front();
          chk("b_rx", b_rx, 8'h3C);
          chk("b_mosi_bits", b_bits, e);
          chk("b_rises", b_rise_n, 8);
        end
        b_rise_n = 0;
      end
      if (c_done) begin
        if (c_q.size() == 0) begin
          chk("c_spurious_done", 1, 0);
        end else begin
          e = c_q.pop_front();
          chk("c_rx", c_rx, e);
          chk("c_mosi_bits", c_bits, e);
          chk("c_first_bit", c_first, e[0]);
        end
        c_rise_n = 0;
      end
    end
    b_sck_p = b_sck;
    c_sck_p = c_sck;
  end

  task automatic wait_done(input int which, input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      seen = (which == 0) ? a_done : (which == 1) ? b_done : c_done;
    end
    if (!seen) chk(tag, 0, 1);
  endtask

  task automatic start_a(input logic [7:0] tx, input logic [1:0] cs);
    for (int k = 0; k < 100 && a_busy; k++) @(negedge clk);
    a_tx = tx;
    a_cs = cs;
    a_start = 1'b1;
    a_q.push_back('{tx: tx, cs: cs});
    @(negedge clk);
    a_start = 1'b0;
  endtask

  initial begin
    int idle_busy;
    repeat (3) @(negedge clk);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_rx", a_rx, 0);
    chk("rst_csn", a_csn, 4'hf);
    chk("rst_sck", a_sck, 0);
    chk("rst_mosi", a_mosi, 0);
    chk("b_idle_sck", b_sck, 1);
    rst = 1'b0;
    @(negedge clk);

    start_a(8'hA5, 2'd0);
    wait_done(0, "a_to_frame1");

    start_a(8'h3C, 2'd2);
    repeat (6) @(negedge clk);
    a_start = 1'b1;
    a_tx = 8'hFF;
    a_cs = 2'd1;
    @(negedge clk);
    a_start = 1'b0;
    wait_done(0, "a_to_frame2");
    repeat (3) @(negedge clk);
    chk("a_no_queue", a_busy, 0);

    a_tx = 8'h5A;
    a_cs = 2'd1;
    a_start = 1'b1;
    a_q.push_back('{tx: 8'h5A, cs: 2'd1});
    wait_done(0, "a_to_held");
    a_tx = 8'hC3;
    a_cs = 2'd3;
    a_q.push_back('{tx: 8'hC3, cs: 2'd3});
    @(negedge clk);
    a_start = 1'b0;
    chk("a_b2b_busy", a_busy, 1);
    wait_done(0, "a_to_b2b");

    b_tx = 8'h96;
    b_start = 1'b1;
    b_q.push_back(8'h96);
    @(negedge clk);
    b_start = 1'b0;
    chk("b_setup_mosi", b_mosi, 0);
    chk("b_setup_sck", b_sck, 1);
    wait_done(1, "b_to_frame");
    chk("b_end_sck", b_sck, 1);

    c_tx = 8'h01;
    c_cs = 2'd1;
    c_start = 1'b1;
    c_q.push_back(8'h01);
    @(negedge clk);
    c_start = 1'b0;
    chk("c_csn", c_csn, 3'b101);
    wait_done(2, "c_to_frame");
    @(negedge clk);
    c_cs = 2'd3;
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    idle_busy = 0;
    for (int k = 0; k < 6; k++) begin
      if (c_busy || c_csn != 3'b111) idle_busy++;
      @(negedge clk);
    end
    chk("c_bad_cs_ignored", idle_busy, 0);

    start_a(8'h77, 2'd1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    a_q.delete();
    @(negedge clk);
    chk("mrst_csn", a_csn, 4'hf);
    chk("mrst_sck", a_sck, 0);
    chk("mrst_busy", a_busy, 0);
    chk("mrst_rx", a_rx, 0);
    chk("mrst_done", a_done, 0);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("mrst_idle", a_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
